// File: rtl/regwrite_scoreboard_pkg.sv
// Shared pipeline definitions used by the register-write scoreboard.
// Architectural register indexing and the zero-register constant.
package processor_pkg;

    localparam int NUM_ARCH_REGS = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZR = 5'd31;

endpackage

// File: rtl/regwrite_scoreboard_sat_counter.sv
// Per-register in-flight write counter with saturation and underflow pulse.
// Clear wins over inc/dec; inc and dec together leave the count unchanged.
module sb_sat_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             at_max,
    output logic             nonzero,
    output logic             udf
);

    logic [CNT_W-1:0] r_count;

    assign count   = r_count;
    assign at_max  = &r_count;
    assign nonzero = |r_count;
    // A lone retire against an empty counter is an underflow; the count holds.
    assign udf     = ~clr & dec & ~inc & ~nonzero;

    // Count issued-but-unretired writes, holding at both ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !dec && !at_max) begin
            r_count <= r_count + 1'b1;
        end else if (dec && !inc && nonzero) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/regwrite_scoreboard.sv
// Register-write scoreboard and issue-stall controller.
// Tracks in-flight writes per register and holds decode on hazards.
module regwrite_scoreboard
    import processor_pkg::*;
#(
    parameter int       NUM_REGS = NUM_ARCH_REGS,
    parameter int       CNT_W    = 2,
    parameter reg_idx_t ZERO_REG = REG_ZR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic                issue_RegWrite,
    input  reg_idx_t            issue_Rd,
    input  reg_idx_t            issue_Rn,
    input  reg_idx_t            issue_Rm,
    input  logic                issue_useRn,
    input  logic                issue_useRm,
    input  logic                wb_RegWrite,
    input  reg_idx_t            wb_Rd,
    input  logic                flush,
    output logic                stall,
    output logic                issue_accept,
    output logic [NUM_REGS-1:0] pending,
    output logic                underflow_err
);

    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_at_max;
    logic [NUM_REGS-1:0] w_nonzero;
    logic [NUM_REGS-1:0] w_udf;
    logic [CNT_W-1:0]    w_count [NUM_REGS];

    logic w_rn_hit;
    logic w_rm_hit;
    logic w_rd_full;
    logic w_stall;
    logic w_accept;
    logic r_underflow;

    // Hazard decode works only from registered counts, never from this cycle's wb.
    always_comb begin
        w_rn_hit  = issue_useRn && (issue_Rn != ZERO_REG) && w_nonzero[issue_Rn];
        w_rm_hit  = issue_useRm && (issue_Rm != ZERO_REG) && w_nonzero[issue_Rm];
        w_rd_full = issue_RegWrite && (issue_Rd != ZERO_REG) && w_at_max[issue_Rd];
        w_stall   = issue_valid && (w_rn_hit || w_rm_hit || w_rd_full);
        w_accept  = issue_valid && !w_stall;
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam reg_idx_t IDX = reg_idx_t'(r);

        // The zero register never counts; flush discards issue and retire alike.
        always_comb begin
            w_inc[r] = !flush && w_accept && issue_RegWrite &&
                       (issue_Rd == IDX) && (IDX != ZERO_REG);
            w_dec[r] = !flush && wb_RegWrite &&
                       (wb_Rd == IDX) && (IDX != ZERO_REG);
        end

        sb_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .clr     (flush),
            .inc     (w_inc[r]),
            .dec     (w_dec[r]),
            .count   (w_count[r]),
            .at_max  (w_at_max[r]),
            .nonzero (w_nonzero[r]),
            .udf     (w_udf[r])
        );

        assign pending[r] = (w_count[r] != '0);
    end

    // Underflow is sticky until reset; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underflow <= 1'b0;
        end else if (|w_udf) begin
            r_underflow <= 1'b1;
        end
    end

    assign stall         = w_stall;
    assign issue_accept  = w_accept;
    assign underflow_err = r_underflow;

endmodule

// File: tb/tb_regwrite_scoreboard.sv
// Directed testbench for regwrite_scoreboard.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_regwrite_scoreboard;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_RegWrite;
    logic [4:0]  issue_Rd;
    logic [4:0]  issue_Rn;
    logic [4:0]  issue_Rm;
    logic        issue_useRn;
    logic        issue_useRm;
    logic        wb_RegWrite;
    logic [4:0]  wb_Rd;
    logic        flush;
    logic        stall;
    logic        issue_accept;
    logic [31:0] pending;
    logic        underflow_err;

    int checks;
    int errors;

    regwrite_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_RegWrite (issue_RegWrite),
        .issue_Rd       (issue_Rd),
        .issue_Rn       (issue_Rn),
        .issue_Rm       (issue_Rm),
        .issue_useRn    (issue_useRn),
        .issue_useRm    (issue_useRm),
        .wb_RegWrite    (wb_RegWrite),
        .wb_Rd          (wb_Rd),
        .flush          (flush),
        .stall          (stall),
        .issue_accept   (issue_accept),
        .pending        (pending),
        .underflow_err  (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_RegWrite = 1'b0;
        issue_Rd       = 5'd0;
        issue_Rn       = 5'd0;
        issue_Rm       = 5'd0;
        issue_useRn    = 1'b0;
        issue_useRm    = 1'b0;
        wb_RegWrite    = 1'b0;
        wb_Rd          = 5'd0;
        flush          = 1'b0;
    endtask

    task automatic iss(input logic [4:0] rd, input logic wr,
                       input logic [4:0] rn, input logic use_rn);
        issue_valid    = 1'b1;
        issue_RegWrite = wr;
        issue_Rd       = rd;
        issue_Rn       = rn;
        issue_useRn    = use_rn;
        issue_Rm       = 5'd0;
        issue_useRm    = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_RegWrite = 1'b1;
        wb_Rd       = rd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1. reset state
        chk("rst_pending", pending, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_udf", {31'd0, underflow_err}, 32'd0);

        // 2. RAW on X3, released one cycle after wb
        iss(5'd3, 1'b1, 5'd0, 1'b0);
        #1;
        chk("raw_first_acc", {31'd0, issue_accept}, 32'd1);
        tick();
        chk("raw_pend3", pending, 32'h0000_0008);
        iss(5'd4, 1'b1, 5'd3, 1'b1);
        #1;
        chk("raw_stall_a", {31'd0, stall}, 32'd1);
        chk("raw_acc_a", {31'd0, issue_accept}, 32'd0);
        tick();
        chk("raw_stall_b", {31'd0, stall}, 32'd1);
        wb(5'd3);
        #1;
        chk("raw_stall_wbcyc", {31'd0, stall}, 32'd1);
        tick();
        wb_RegWrite = 1'b0;
        #1;
        chk("raw_release", {31'd0, stall}, 32'd0);
        chk("raw_pend_clr", pending, 32'h0);
        tick();
        idle();
        chk("raw_pend4", pending, 32'h0000_0010);
        wb(5'd4);
        tick();
        idle();
        chk("raw_drain", pending, 32'h0);

        // 3. saturate X5 at three in-flight writes
        for (int i = 0; i < 3; i++) begin
            iss(5'd5, 1'b1, 5'd0, 1'b0);
            #1;
            chk("sat_acc", {31'd0, issue_accept}, 32'd1);
            tick();
        end
        iss(5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        chk("sat_fourth_stall", {31'd0, stall}, 32'd1);
        chk("sat_pend5", pending, 32'h0000_0020);
        wb(5'd5);
        #1;
        chk("sat_stall_wbcyc", {31'd0, stall}, 32'd1);
        tick();
        wb_RegWrite = 1'b0;
        #1;
        chk("sat_fourth_acc", {31'd0, issue_accept}, 32'd1);
        tick();
        chk("sat_full_again", {31'd0, stall}, 32'd1);
        idle();
        wb(5'd5);
        tick();
        tick();
        chk("sat_pend_after2", pending, 32'h0000_0020);
        tick();
        idle();
        chk("sat_drained", pending, 32'h0);
        chk("sat_no_udf", {31'd0, underflow_err}, 32'd0);

        // 4. simultaneous issue and retire on X7
        iss(5'd7, 1'b1, 5'd0, 1'b0);
        tick();
        wb(5'd7);
        #1;
        chk("sim_acc", {31'd0, issue_accept}, 32'd1);
        tick();
        idle();
        chk("sim_pend7", pending, 32'h0000_0080);
        wb(5'd7);
        tick();
        idle();
        chk("sim_count_was1", pending, 32'h0);
        chk("sim_no_udf", {31'd0, underflow_err}, 32'd0);

        // 5. zero register on every port
        iss(5'd31, 1'b1, 5'd31, 1'b1);
        issue_Rm    = 5'd31;
        issue_useRm = 1'b1;
        wb(5'd31);
        #1;
        chk("zr_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        chk("zr_pend", pending, 32'h0);
        chk("zr_udf", {31'd0, underflow_err}, 32'd0);

        // 6. flush with concurrent issue to X4
        iss(5'd1, 1'b1, 5'd0, 1'b0);
        tick();
        iss(5'd2, 1'b1, 5'd0, 1'b0);
        tick();
        chk("fl_pend12", pending, 32'h0000_0006);
        iss(5'd4, 1'b1, 5'd1, 1'b1);
        flush = 1'b1;
        #1;
        chk("fl_stall_eval", {31'd0, stall}, 32'd1);
        issue_useRn = 1'b0;
        #1;
        chk("fl_acc", {31'd0, issue_accept}, 32'd1);
        tick();
        idle();
        chk("fl_pend0", pending, 32'h0);
        chk("fl_udf", {31'd0, underflow_err}, 32'd0);

        // 7. underflow on X9, sticky through flush, cleared by reset
        wb(5'd9);
        tick();
        idle();
        chk("udf_set", {31'd0, underflow_err}, 32'd1);
        chk("udf_pend", pending, 32'h0);
        flush = 1'b1;
        tick();
        idle();
        chk("udf_sticky", {31'd0, underflow_err}, 32'd1);
        iss(5'd6, 1'b1, 5'd0, 1'b0);
        tick();
        chk("mid_pend6", pending, 32'h0000_0040);
        reset = 1'b1;
        iss(5'd8, 1'b1, 5'd0, 1'b0);
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("mid_rst_pend", pending, 32'h0);
        chk("mid_rst_udf", {31'd0, underflow_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
